data_arith_imm_split: RTL and testbench
=======================================

DATA_ARITH_IMM_SPLIT -- requirements
Module: data_arith_imm_split

Interface
REQ-001 Parameter IN_W, 32, instruction word width.
REQ-002 Parameter IMM_W, 16, immediate field width (instr[IMM_W-1:0]).
REQ-003 ctrl.clock  input  1  Data_Control bundle clock; all state on rising edge.
REQ-004 ctrl.reset  input  1  Data_Control bundle reset; asynchronous, active-low.
REQ-005 in_instr  input  IN_W  instruction word from fetch/decode.
REQ-006 in_valid  input  1  in_instr valid.
REQ-007 in_ready  output  1  block can accept; transfer when in_valid && in_ready.
REQ-008 out_imm  output  IMM_W  immediate field, feeds the extend stage.
REQ-009 out_sign  output  1  1 = extend stage sign-extends, 0 = zero-extends.
REQ-010 out_lui  output  1  1 = immediate is a LUI upper-half load.
REQ-011 out_valid  output  1  out_* valid.
REQ-012 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-013 occupancy  output  2  entries held (0..2).

Function
REQ-014 Block SHALL be a 2-entry skid buffer: main register (drives out_*) plus skid register.
REQ-015 States SHALL be EMPTY (0 entries), ONE (main full), TWO (main+skid full); occupancy = 0/1/2.
REQ-016 in_ready SHALL be registered and equal 1 iff next state != TWO; no combinational path out_ready -> in_ready.
REQ-017 EMPTY: in fire -> main <= decoded input, ONE; else stay.
REQ-018 ONE: in fire only -> skid <= input, TWO; out fire only -> EMPTY; both -> main <= input, stay ONE.
REQ-019 TWO: out fire -> main <= skid, ONE; in fire impossible (in_ready = 0).
REQ-020 Latency SHALL be 1 cycle: word accepted at edge N is presented on out_* after edge N when main was empty or emptying.
REQ-021 Ordering SHALL be strict FIFO; no word dropped or duplicated under any in/out fire pattern.
REQ-022 out_* SHALL hold stable while out_valid && !out_ready.
REQ-023 Decode at capture: imm = instr[IMM_W-1:0]; sign = 0 when instr[31:26] in {0x0C ANDI, 0x0D ORI, 0x0E XORI}, else 1.
REQ-024 out_valid SHALL be 1 iff state != EMPTY.
REQ-025 Words with in_valid=0 SHALL not affect state regardless of in_instr.

Reset
REQ-026 Reset asserted (ctrl.reset=0) SHALL immediately force state EMPTY, out_valid 0, in_ready 0, occupancy 0, out_imm 0, out_sign 0, out_lui 0, skid 0.
REQ-027 in_ready SHALL rise on the first rising edge after reset deassertion.
REQ-028 Reset mid-transfer SHALL discard all held words; nothing held is emitted after reset.

Configuration
REQ-029 Macro DATA_ARITH_IMM_SPLIT_LUI_EN defined: out_lui = 1 and out_sign = 0 when instr[31:26] = 0x0F, else out_lui = 0.
REQ-030 Macro undefined: out_lui SHALL be tied 0, no LUI decode logic, LUI treated as sign-extend opcode.

Verification
REQ-031 Reset release, in_valid=1 instr=0x2008FFFF (ADDI) -> next cycle out_valid=1, out_imm=0xFFFF, out_sign=1, occupancy=1.
REQ-032 out_ready=0, feed 0x3108_8000 (ANDI) then 0x3508_0001 (ORI) -> occupancy=2, in_ready=0, out_imm holds 0x8000 sign=0; raise out_ready -> 0x8000 then 0x0001 in order.
REQ-033 Continuous in_valid=out_ready=1, 100 random words -> one output per cycle, order preserved, occupancy stays 1.
REQ-034 LUI 0x3C011234 with macro -> out_imm=0x1234, out_lui=1, out_sign=0; without macro -> out_lui=0, out_sign=1.
REQ-035 Assert reset while occupancy=2 -> same instant out_valid=0, occupancy=0; after release no stale word emitted.

Source files
------------

// File: rtl/data_arith_imm_split_if.sv
// Data_Control bundle for data_arith_imm_split: clock and asynchronous active-low reset.
// The bench drives it through the master modport; the splitter samples it through the slave modport.
interface data_arith_imm_split_if;
    logic clock;
    logic reset;

    modport master (output clock, output reset);
    modport slave  (input  clock, input  reset);
endinterface

// File: rtl/data_arith_imm_split.sv
// Immediate splitter: a 2-entry skid buffer that decodes the immediate and its extend mode at capture.
// Optional LUI decode is enabled by defining DATA_ARITH_IMM_SPLIT_LUI_EN.
module data_arith_imm_split #(
    parameter int IN_W  = 32,
    parameter int IMM_W = 16
) (
    data_arith_imm_split_if.slave ctrl,
    input  logic [IN_W-1:0]  in_instr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_sign,
    output logic             out_lui,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [1:0]       dbg_state
);

    // Handshake: a word moves on a side only in a cycle where that side's valid and ready
    // are both high. in_ready is a flop, so out_ready never reaches it combinationally.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic             sign;
        logic             lui;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   in_fire, out_fire;
    entry_t in_dec;
    logic   unused_instr_bits;

    always_comb begin
        logic [5:0] opcode;
        opcode      = in_instr[IN_W-1 -: 6];
        in_dec.imm  = in_instr[IMM_W-1:0];
        in_dec.sign = !(opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E);
        in_dec.lui  = 1'b0;
`ifdef DATA_ARITH_IMM_SPLIT_LUI_EN
        if (opcode == 6'h0F) begin
            in_dec.lui  = 1'b1;
            in_dec.sign = 1'b0;
        end
`endif
    end

    // The bits between the immediate and the opcode carry register fields that this block ignores.
    assign unused_instr_bits = ^in_instr[IN_W-7:IMM_W];

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = (state_q != S_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_dec;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_dec;
                end else if (in_fire) begin
                    skid_d  = in_dec;
                    state_d = S_TWO;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only the output side can move.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge ctrl.clock or negedge ctrl.reset) begin
        if (!ctrl.reset) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_imm   = main_q.imm;
    assign out_sign  = main_q.sign;
    assign out_lui   = main_q.lui;
    assign occupancy = state_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_arith_imm_split.sv
// Directed bench for data_arith_imm_split: vector table, FIFO stream with scoreboard, reset-while-full.
// Expected LUI behaviour follows DATA_ARITH_IMM_SPLIT_LUI_EN.
module tb_data_arith_imm_split;

`ifdef DATA_ARITH_IMM_SPLIT_LUI_EN
    localparam bit LUI_EN = 1'b1;
`else
    localparam bit LUI_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_imm;
    logic        out_sign;
    logic        out_lui;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occupancy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];

    data_arith_imm_split_if ctrl_if ();
    assign ctrl_if.clock = clk;
    assign ctrl_if.reset = rst_n;

    data_arith_imm_split #(.IN_W(32), .IMM_W(16)) dut (
        .ctrl      (ctrl_if.slave),
        .in_instr  (in_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_imm   (out_imm),
        .out_sign  (out_sign),
        .out_lui   (out_lui),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic        ordy;
        logic        ev;
        logic [15:0] eimm;
        logic        esign;
        logic        elui;
        logic [1:0]  eocc;
        logic        erdy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode, packed as {imm, sign, lui}.
    function automatic logic [17:0] ref_dec(input logic [31:0] w);
        logic [5:0] op;
        logic       sign;
        logic       lui;
        op   = w[31:26];
        sign = !(op == 6'h0C || op == 6'h0D || op == 6'h0E);
        lui  = 1'b0;
        if (LUI_EN && op == 6'h0F) begin
            lui  = 1'b1;
            sign = 1'b0;
        end
        return {w[15:0], sign, lui};
    endfunction

    task automatic drive(input logic iv, input logic [31:0] instr, input logic ordy);
        in_valid  = iv;
        in_instr  = instr;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [17:0] e;
        int          sent;
        int          cyc;

        vecs[0] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[1] = '{1'b1, 32'h2008_FFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[2] = '{1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[3] = '{1'b1, 32'h3108_8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[4] = '{1'b1, 32'h3508_0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[5] = '{1'b1, 32'h1111_1111, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[7] = '{1'b1, 32'h3C01_1234, 1'b1, 1'b1, 16'h1234, !LUI_EN, LUI_EN, 2'd1, 1'b1};
        vecs[8] = '{1'b1, 32'h38AA_5555, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_occupancy", {30'b0, occupancy}, 32'd0);
        check("rst_out_imm",   {16'b0, out_imm},   32'd0);
        check("rst_out_sign",  {31'b0, out_sign},  32'd0);
        check("rst_out_lui",   {31'b0, out_lui},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: each entry is one clock; outputs checked just after the edge.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].instr, vecs[i].ordy);
            step();
            check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            check($sformatf("v%0d_occupancy", i), {30'b0, occupancy}, {30'b0, vecs[i].eocc});
            check($sformatf("v%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].erdy});
            if (vecs[i].ev) begin
                check($sformatf("v%0d_out_imm", i),  {16'b0, out_imm},  {16'b0, vecs[i].eimm});
                check($sformatf("v%0d_out_sign", i), {31'b0, out_sign}, {31'b0, vecs[i].esign});
                check($sformatf("v%0d_out_lui", i),  {31'b0, out_lui},  {31'b0, vecs[i].elui});
            end
        end

        // Streaming: in_valid and out_ready held high for 100 words, scoreboard on both fires.
        sent = 0;
        cyc  = 0;
        while ((sent < 100 || exp_q.size() != 0) && cyc < 130) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[31:26] = 6'($urandom_range(12, 15));
            drive(sent < 100, w, 1'b1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_word", {16'b0, out_imm}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("stream_word%0d", cyc), {14'b0, out_imm, out_sign, out_lui}, {14'b0, e});
                end
            end else if (sent >= 1 && sent < 100) begin
                check($sformatf("stream_gap%0d", cyc), {31'b0, out_valid}, 32'd1);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_dec(in_instr));
                sent++;
            end
            step();
            cyc++;
            if (sent >= 1 && sent < 100)
                check($sformatf("stream_occ%0d", cyc), {30'b0, occupancy}, 32'd1);
        end
        check("stream_all_sent", sent, 100);
        check("stream_queue_empty", exp_q.size(), 0);
        check("stream_drained_valid", {31'b0, out_valid}, 32'd0);

        // Reset while both entries are held.
        drive(1'b1, 32'h3108_AAAA, 1'b0);
        step();
        drive(1'b1, 32'h2008_BBBB, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        check("full_occupancy", {30'b0, occupancy}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_occupancy", {30'b0, occupancy}, 32'd0);
        check("midrst_in_ready",  {31'b0, in_ready},  32'd0);
        check("midrst_out_imm",   {16'b0, out_imm},   32'd0);
        check("midrst_out_sign",  {31'b0, out_sign},  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        step();
        check("postrst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("postrst_stale%0d", k), {31'b0, out_valid}, 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
